// File: rtl/expr_sweep_pkg.sv
// Shared types and constants for the expression self-test sweep.
package expr_sweep_pkg;

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, HOLD, DONE} state_t;

    localparam int          NUM_VECTORS = 16;
    localparam logic [15:0] GOLDEN_MAP  = 16'h4FFF;

endpackage

// File: rtl/expr_golden.sv
// Combinational reference for Y = (ab)' + cd'.
module expr_golden (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y_ref
);

    assign y_ref = ~(a & b) | (c & ~d);

endmodule

// File: rtl/expr_sweep_controller.sv
// Sweeps all 16 {a,b,c,d} vectors through the expression DUT and scores y_dut.
// Optional macro EXPR_SWEEP_STEP_MODE_EN: HOLD advances on a step rising edge.
module expr_sweep_controller
    import expr_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        y_dut,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [4:0]  err_count,
    output logic [15:0] result_map,
    output logic [3:0]  vec_idx
`ifdef EXPR_SWEEP_STEP_MODE_EN
    ,
    input  logic        step
`endif
);

    localparam int MAX_CYC = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC);
`ifdef EXPR_SWEEP_STEP_MODE_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = (HOLD_CYCLES > 0);
`endif

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic              clr, smp, adv, cnt_inc, hold_end, last, y_ref;

    expr_golden u_golden (
        .a     (vec_idx[3]),
        .b     (vec_idx[2]),
        .c     (vec_idx[1]),
        .d     (vec_idx[0]),
        .y_ref (y_ref)
    );

    assign {a, b, c, d} = vec_idx;
    assign last = (vec_idx == 4'(NUM_VECTORS - 1));
    assign busy = (state == SETTLE) || (state == SAMPLE) || (state == HOLD);
    assign done = (state == DONE);
    assign pass = done && (err_count == 5'd0);

`ifdef EXPR_SWEEP_STEP_MODE_EN
    logic step_q;
    always_ff @(posedge clk) begin
        if (rst) step_q <= 1'b0;
        else     step_q <= step;
    end
    assign hold_end = step & ~step_q;
`else
    assign hold_end = (int'(cnt) == HOLD_CYCLES - 1);
`endif

    always_comb begin
        state_n = state;
        clr     = 1'b0;
        smp     = 1'b0;
        adv     = 1'b0;
        cnt_inc = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n = SETTLE;
                    clr     = 1'b1;
                end
            end
            SETTLE: begin
                if (int'(cnt) == SETTLE_CYCLES - 1) state_n = SAMPLE;
                else                                cnt_inc = 1'b1;
            end
            SAMPLE: begin
                smp = 1'b1;
                if (HOLD_EN)   state_n = HOLD;
                else if (last) state_n = DONE;
                else begin
                    adv     = 1'b1;
                    state_n = SETTLE;
                end
            end
            HOLD: begin
                if (!hold_end) cnt_inc = 1'b1;
                else if (last) state_n = DONE;
                else begin
                    adv     = 1'b1;
                    state_n = SETTLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The counter idles at zero so every SETTLE/HOLD phase starts fresh.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            vec_idx    <= 4'd0;
            err_count  <= 5'd0;
            result_map <= 16'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_inc ? cnt + 1'b1 : '0;
            if (clr) begin
                vec_idx    <= 4'd0;
                err_count  <= 5'd0;
                result_map <= 16'd0;
            end else begin
                if (adv) vec_idx <= vec_idx + 4'd1;
                if (smp) begin
                    result_map[vec_idx] <= y_dut;
                    if (y_dut != y_ref) err_count <= err_count + 5'd1;
                end
            end
        end
    end

endmodule
